// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache between an 8-bit CPU port and a 32-bit block memory.
// Misses stall the CPU while the FSM writes back a dirty victim and refills the line.
module dcache_controller #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-3:0] MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic [31:0]       MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic [CNT_W-1:0]  HIT_COUNT,
    output logic [CNT_W-1:0]  MISS_COUNT
);

    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, WBACK, FETCH, UPDATE} state_t;

    state_t state, state_nx;

    logic [31:0]           data [NUM_BLOCKS];
    logic [TAG_W-1:0]      tags [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;
    logic [31:0]           fill_q;
    logic [7:0]            rd_q;
    logic                  refill_done;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         off;
    logic               req;
    logic               hit;
    logic               serve;
    logic [7:0]         sel_byte;

    assign idx      = ADDRESS[INDEX_W+1:2];
    assign tag      = ADDRESS[ADDR_W-1:INDEX_W+2];
    assign off      = ADDRESS[1:0];
    assign req      = READ | WRITE;
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign serve    = (state == IDLE) && req && hit;
    assign sel_byte = data[idx][{off, 3'b000} +: 8];
    assign BUSYWAIT = req && !((state == IDLE) && hit);
    assign READDATA = serve ? sel_byte : rd_q;

    always_comb begin
        state_nx      = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        unique case (state)
            IDLE: begin
                if (req && !hit)
                    state_nx = dirty[idx] ? WBACK : FETCH;
            end
            WBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tags[idx], idx};
                MEM_WRITEDATA = data[idx];
                if (!MEM_BUSYWAIT)
                    state_nx = FETCH;
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[ADDR_W-1:2];
                if (!MEM_BUSYWAIT)
                    state_nx = UPDATE;
            end
            UPDATE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            fill_q      <= '0;
            rd_q        <= '0;
            refill_done <= 1'b0;
            HIT_COUNT   <= '0;
            MISS_COUNT  <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && !MEM_BUSYWAIT)
                fill_q <= MEM_READDATA;
            if (state == UPDATE) begin
                valid[idx]  <= 1'b1;
                dirty[idx]  <= 1'b0;
                refill_done <= 1'b1;
            end
            if (state == IDLE)
                refill_done <= 1'b0;
            // the access that caused a refill already counted as a miss
            if (serve) begin
                rd_q <= sel_byte;
                if (WRITE)
                    dirty[idx] <= 1'b1;
                if (!refill_done && HIT_COUNT != '1)
                    HIT_COUNT <= HIT_COUNT + CNT_W'(1);
            end
            if (state == IDLE && req && !hit && MISS_COUNT != '1)
                MISS_COUNT <= MISS_COUNT + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data[idx] <= fill_q;
            tags[idx] <= tag;
        end else if (serve && WRITE) begin
            data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, reset and saturation sequences,
// and random accesses checked against a byte-array memory plus tag-array cache model.
module tb_dcache_controller;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;

    dcache_controller dut (
        .CLK(CLK),
        .RESET(RESET),
        .READ(READ),
        .WRITE(WRITE),
        .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .HIT_COUNT(HIT_COUNT),
        .MISS_COUNT(MISS_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // memory: busy for lat cycles of each request, completes on the following edge
    typedef struct {
        bit          wr;
        logic [5:0]  blk;
        logic [31:0] data;
    } mop_t;

    logic [31:0] mem [64];
    bit          written [64];
    int          mcnt;
    int          lat;
    mop_t        mlog [$];

    function automatic logic [31:0] init_blk(logic [5:0] b);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = {b, 2'(k)} ^ 8'h5A;
        return r;
    endfunction

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != lat);

    always_comb begin
        MEM_READDATA = 32'h0;
        if (MEM_READ)
            MEM_READDATA = written[MEM_ADDRESS] ? mem[MEM_ADDRESS]
                                                : init_blk(MEM_ADDRESS);
    end

    always @(posedge CLK) begin
        if (!(MEM_READ || MEM_WRITE)) begin
            mcnt <= 0;
        end else if (mcnt == lat) begin
            mcnt <= 0;
            mlog.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
            if (MEM_WRITE) begin
                mem[MEM_ADDRESS]     <= MEM_WRITEDATA;
                written[MEM_ADDRESS] <= 1'b1;
            end
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_access(input bit r, input bit w, input logic [7:0] a,
                             input logic [7:0] d, input int l,
                             output int stall, output logic [7:0] rdata);
        @(negedge CLK);
        lat       = l;
        READ      = r;
        WRITE     = w;
        ADDRESS   = a;
        WRITEDATA = d;
        #1;
        stall = 0;
        while (BUSYWAIT && stall < 1000) begin
            @(negedge CLK);
            #1;
            stall++;
        end
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    // reference model: flat byte memory plus per-line tag/valid/dirty
    logic [7:0] gold [256];
    int         rtag [8];
    bit         rvalid [8];
    bit         rdirty [8];
    int         hits_m;
    int         miss_m;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 256; a++) begin
            logic [7:0]  ab;
            logic [5:0]  b;
            logic [31:0] blk;
            ab  = 8'(a);
            b   = ab[7:2];
            blk = written[b] ? mem[b] : init_blk(b);
            gold[a] = blk[8*ab[1:0] +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            rvalid[i] = 1'b0;
            rdirty[i] = 1'b0;
            rtag[i]   = 0;
        end
        hits_m = 0;
        miss_m = 0;
    endtask

    task automatic model_access(input bit r, input bit w, input logic [7:0] a,
                                input logic [7:0] d, input int l);
        int         ix;
        int         tg;
        int         exp_stall;
        int         stall;
        logic [7:0] exp_rd;
        logic [7:0] rdata;
        ix = int'(a[4:2]);
        tg = int'(a[7:5]);
        if (rvalid[ix] && rtag[ix] == tg) begin
            exp_stall = 0;
            hits_m    = sat(hits_m + 1);
        end else begin
            exp_stall  = rdirty[ix] ? 2 * l + 4 : l + 3;
            miss_m     = sat(miss_m + 1);
            rvalid[ix] = 1'b1;
            rtag[ix]   = tg;
            rdirty[ix] = 1'b0;
        end
        exp_rd = gold[a];
        if (w) begin
            gold[a]    = d;
            rdirty[ix] = 1'b1;
        end
        do_access(r, w, a, d, l, stall, rdata);
        check($sformatf("rnd_stall@%0h", a), stall, exp_stall);
        if (!w) begin
            check($sformatf("rnd_rdata@%0h", a), rdata, exp_rd);
            check($sformatf("rnd_hold@%0h", a), READDATA, exp_rd);
        end
        check("rnd_hits", HIT_COUNT, hits_m);
        check("rnd_misses", MISS_COUNT, miss_m);
    endtask

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wd;
        int         l;
        int         stall;
        int         ops;
        logic [7:0] rdv;
        int         hits;
        int         misses;
        bit         wb;
        logic [5:0] wb_blk;
        logic [7:0] wb_b0;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int         stall;
        int         base;
        int         n1;
        logic [7:0] rdata;
        logic [7:0] ra;

        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h0;
        WRITEDATA = 8'h0;
        lat       = 1;

        tbl[0] = '{1, 0, 8'h14, 8'h00, 5, 8, 1, 8'h4E, 0, 1, 0, 6'h00, 8'h00};
        tbl[1] = '{1, 0, 8'h15, 8'h00, 5, 0, 0, 8'h4F, 1, 1, 0, 6'h00, 8'h00};
        tbl[2] = '{0, 1, 8'h14, 8'hAB, 5, 0, 0, 8'h00, 2, 1, 0, 6'h00, 8'h00};
        tbl[3] = '{1, 0, 8'h34, 8'h00, 2, 8, 2, 8'h6E, 2, 2, 1, 6'h05, 8'hAB};
        tbl[4] = '{1, 0, 8'h14, 8'h00, 1, 4, 1, 8'hAB, 2, 3, 0, 6'h00, 8'h00};
        tbl[5] = '{1, 1, 8'h00, 8'h77, 1, 4, 1, 8'h00, 2, 4, 0, 6'h00, 8'h00};
        tbl[6] = '{1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h77, 3, 4, 0, 6'h00, 8'h00};
        tbl[7] = '{1, 0, 8'h20, 8'h00, 1, 6, 2, 8'h7A, 3, 5, 1, 6'h00, 8'h77};
        tbl[8] = '{1, 0, 8'h00, 8'h00, 3, 6, 1, 8'h77, 3, 6, 0, 6'h00, 8'h00};
        tbl[9] = '{1, 0, 8'h03, 8'h00, 0, 0, 0, 8'h59, 4, 6, 0, 6'h00, 8'h00};

        repeat (2) @(negedge CLK);
        #1;
        check("rst_readdata", READDATA, 8'h00);
        check("rst_busywait", BUSYWAIT, 1'b0);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_mem_write", MEM_WRITE, 1'b0);
        check("rst_mem_addr", MEM_ADDRESS, 6'h00);
        check("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
        check("rst_hits", HIT_COUNT, 16'h0);
        check("rst_misses", MISS_COUNT, 16'h0);
        RESET = 1'b0;

        for (int i = 0; i < 10; i++) begin
            base = mlog.size();
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].l,
                      stall, rdata);
            check($sformatf("row%0d_stall", i), stall, tbl[i].stall);
            check($sformatf("row%0d_memops", i), mlog.size() - base, tbl[i].ops);
            if (!tbl[i].wr) begin
                check($sformatf("row%0d_rdata", i), rdata, tbl[i].rdv);
                check($sformatf("row%0d_hold", i), READDATA, tbl[i].rdv);
            end
            check($sformatf("row%0d_hits", i), HIT_COUNT, tbl[i].hits);
            check($sformatf("row%0d_misses", i), MISS_COUNT, tbl[i].misses);
            if (tbl[i].ops > 0 && mlog.size() > base) begin
                check($sformatf("row%0d_fetch_wr", i), mlog[mlog.size()-1].wr, 1'b0);
                check($sformatf("row%0d_fetch_blk", i), mlog[mlog.size()-1].blk,
                      tbl[i].addr[7:2]);
            end
            if (tbl[i].wb && mlog.size() > base) begin
                check($sformatf("row%0d_wb_wr", i), mlog[base].wr, 1'b1);
                check($sformatf("row%0d_wb_blk", i), mlog[base].blk, tbl[i].wb_blk);
                check($sformatf("row%0d_wb_byte0", i), mlog[base].data[7:0],
                      tbl[i].wb_b0);
            end
        end

        // reset in the third FETCH cycle
        @(negedge CLK);
        lat     = 5;
        READ    = 1'b1;
        ADDRESS = 8'h44;
        repeat (3) @(negedge CLK);
        #1;
        check("mid_fetch_mem_read", MEM_READ, 1'b1);
        RESET = 1'b1;
        #1;
        check("rst_fetch_mem_read", MEM_READ, 1'b0);
        check("rst_fetch_mem_write", MEM_WRITE, 1'b0);
        check("rst_fetch_mem_addr", MEM_ADDRESS, 6'h00);
        check("rst_fetch_misses", MISS_COUNT, 16'h0);
        @(negedge CLK);
        READ  = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        check("post_rst_idle", MEM_READ | MEM_WRITE | BUSYWAIT, 1'b0);
        model_reset();
        model_access(1, 0, 8'h44, 8'h00, 1);
        model_access(1, 0, 8'h45, 8'h00, 1);
        model_access(1, 0, 8'h46, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 3);
            ra = 8'($urandom_range(0, 127));
            model_access(op != 0, op <= 1, ra, 8'($urandom), $urandom_range(0, 3));
        end

        // counter saturation with a continuous stream of hits
        model_access(1, 0, 8'h44, 8'h00, 1);
        n1 = 65534 - hits_m;
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 8'h44;
        repeat (n1) @(posedge CLK);
        #1;
        check("hits_near_sat", HIT_COUNT, 16'hFFFE);
        repeat (65537 - n1) @(posedge CLK);
        #1;
        check("hits_sat", HIT_COUNT, 16'hFFFF);
        check("sat_no_stall", BUSYWAIT, 1'b0);
        check("sat_misses", MISS_COUNT, miss_m);
        READ = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
